array_bin_mult: RTL and testbench

//  Pipelined 16x16 unsigned binary array multiplier: a 16-row carry-save array of

---
 rtl/array_bin_mult_pkg.sv | 5 +
 rtl/array_bin_mult_fa_cell.sv | 11 +
 rtl/array_bin_mult.sv | 113 +++++++++++
 tb/tb_array_bin_mult.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/array_bin_mult_pkg.sv
// Shared width constants for the array multiplier slice.
package array_bin_mult_pkg;
    localparam int W  = 16;
    localparam int PW = 2 * W;
endpackage

// File: rtl/array_bin_mult_fa_cell.sv
// One-bit full adder used as the building block of the multiplier array.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/array_bin_mult.sv
// Two-stage unsigned W x W multiplier: registered operands, carry-save array of
// full-adder rows, ripple-carry final row, registered product.
module array_bin_mult
    import array_bin_mult_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  mlier,
    input  logic [W-1:0]  mcand,
    output logic [PW-1:0] prodt,
    output logic          valid
);
    logic [W-1:0]  a_p1;
    logic [W-1:0]  b_p1;
    logic          vld_p1;
    logic [W-1:0]  pp [W];
    logic [PW-1:0] prod_c;

    // Stage 1: operand capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_p1   <= '0;
            b_p1   <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= start;
            if (start) begin
                a_p1 <= mlier;
                b_p1 <= mcand;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < W; i++) begin
            pp[i] = a_p1 & {W{b_p1[i]}};
        end
    end

    assign prod_c[0] = pp[0][0];

    // Row i holds sum bits of weight i+j and carry bits of weight i+j+1;
    // its bit 0 is already final and becomes product bit i.
    for (genvar i = 1; i < W; i++) begin : row
        logic [W-1:0] s_v;
        logic [W-1:0] c_v;
        for (genvar j = 0; j < W; j++) begin : col
            logic sin;
            logic cin;
            if (i == 1) begin : g_first
                assign cin = 1'b0;
                if (j < W - 1) begin : g_in
                    assign sin = pp[0][j+1];
                end else begin : g_top
                    assign sin = 1'b0;
                end
            end else begin : g_rest
                assign cin = row[i-1].c_v[j];
                if (j < W - 1) begin : g_in
                    assign sin = row[i-1].s_v[j+1];
                end else begin : g_top
                    assign sin = 1'b0;
                end
            end
            fa_cell u_fa (
                .a   (pp[i][j]),
                .b   (sin),
                .cin (cin),
                .sum (s_v[j]),
                .cout(c_v[j])
            );
        end
        assign prod_c[i] = s_v[0];
    end

    // Final carry out of the ripple row is always zero for unsigned operands.
    for (genvar j = 0; j < W; j++) begin : rip
        logic b_in;
        logic ci;
        logic co;
        if (j < W - 1) begin : g_in
            assign b_in = row[W-1].s_v[j+1];
        end else begin : g_top
            assign b_in = 1'b0;
        end
        if (j == 0) begin : g_c0
            assign ci = 1'b0;
        end else begin : g_cn
            assign ci = rip[j-1].co;
        end
        fa_cell u_fa (
            .a   (row[W-1].c_v[j]),
            .b   (b_in),
            .cin (ci),
            .sum (prod_c[W+j]),
            .cout(co)
        );
    end

    // Stage 2: product register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prodt <= '0;
            valid <= 1'b0;
        end else begin
            valid <= vld_p1;
            if (vld_p1) begin
                prodt <= prod_c;
            end
        end
    end
endmodule

// File: tb/tb_array_bin_mult.sv
// Directed and streamed-random checks of the two-stage array multiplier.
module tb_array_bin_mult;
    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] mlier;
    logic [15:0] mcand;
    logic [31:0] prodt;
    logic        valid;

    int total;
    int bad;

    array_bin_mult dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .mlier(mlier),
        .mcand(mcand),
        .prodt(prodt),
        .valid(valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one full cycle: through the next rising edge to the falling edge.
    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mlier = 16'h1111 * 16'(k + 1);
            mcand = 16'h0F0F + 16'(k);
            cyc();
            total++;
            if (prodt !== 32'h0 || valid !== 1'b0) begin
                $display("FAIL reset_hold k=%0d: prodt=%h valid=%b, want prodt=0 valid=0", k, prodt, valid);
                bad++;
            end
        end
        start = 1'b0;
        reset = 1'b1;
        cyc();
        start = 1'b1;
        mlier = 16'd3;
        mcand = 16'd5;
        cyc();
        total++;
        if (valid !== 1'b0) begin
            $display("FAIL reset_release_1edge: valid=%b, want 0", valid);
            bad++;
        end
        cyc();
        total++;
        if (valid !== 1'b1 || prodt !== 32'd15) begin
            $display("FAIL reset_release_2edge: prodt=%h valid=%b, want 0000000f 1", prodt, valid);
            bad++;
        end
    endtask

    task automatic test_basic();
        start = 1'b1;
        mlier = 16'h9797;
        mcand = 16'hD4D4;
        cyc();
        cyc();
        total++;
        if (prodt !== 32'h7E06950C || valid !== 1'b1) begin
            $display("FAIL basic: prodt=%h valid=%b, want 7e06950c 1", prodt, valid);
            bad++;
        end
    endtask

    task automatic test_stream_change();
        mcand = 16'hDEDE;
        cyc();
        total++;
        if (prodt !== 32'h7E06950C || valid !== 1'b1) begin
            $display("FAIL change_1edge: prodt=%h valid=%b, want 7e06950c 1", prodt, valid);
            bad++;
        end
        cyc();
        total++;
        if (prodt !== 32'h83F866F2 || valid !== 1'b1) begin
            $display("FAIL change_2edge: prodt=%h valid=%b, want 83f866f2 1", prodt, valid);
            bad++;
        end
    endtask

    task automatic test_corners();
        mlier = 16'h1515;
        mcand = 16'hDFDF;
        cyc();
        cyc();
        total++;
        if (prodt !== 32'h126FA84B) begin
            $display("FAIL corner_1515: prodt=%h, want 126fa84b", prodt);
            bad++;
        end
        mlier = 16'hFFFF;
        mcand = 16'hFFFF;
        cyc();
        cyc();
        total++;
        if (prodt !== 32'hFFFE0001) begin
            $display("FAIL corner_max: prodt=%h, want fffe0001", prodt);
            bad++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] am [3];
        logic [15:0] bm [3];
        logic [31:0] rs [3];
        am[0] = 16'h0000; bm[0] = 16'h1234; rs[0] = 32'h00000000;
        am[1] = 16'h0001; bm[1] = 16'hFFFF; rs[1] = 32'h0000FFFF;
        am[2] = 16'h8000; bm[2] = 16'h8000; rs[2] = 32'h40000000;
        start = 1'b1;
        mlier = am[0];
        mcand = bm[0];
        cyc();
        mlier = am[1];
        mcand = bm[1];
        cyc();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (prodt !== rs[k] || valid !== 1'b1) begin
                $display("FAIL b2b_%0d: prodt=%h valid=%b, want %h 1", k, prodt, valid, rs[k]);
                bad++;
            end
            if (k == 0) begin
                mlier = am[2];
                mcand = bm[2];
            end else begin
                start = 1'b0;
                mlier = 16'hAAAA;
                mcand = 16'h5555;
            end
            cyc();
        end
        total++;
        if (prodt !== rs[2] || valid !== 1'b1) begin
            $display("FAIL b2b_2: prodt=%h valid=%b, want %h 1", prodt, valid, rs[2]);
            bad++;
        end
        cyc();
        total++;
        if (prodt !== rs[2] || valid !== 1'b0) begin
            $display("FAIL stop_hold: prodt=%h valid=%b, want %h 0", prodt, valid, rs[2]);
            bad++;
        end
        cyc();
        total++;
        if (prodt !== rs[2] || valid !== 1'b0) begin
            $display("FAIL stop_hold2: prodt=%h valid=%b, want %h 0", prodt, valid, rs[2]);
            bad++;
        end
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        mlier = 16'h00FF;
        mcand = 16'h0101;
        cyc();
        cyc();
        total++;
        if (prodt !== 32'h0000FFFF || valid !== 1'b1) begin
            $display("FAIL pre_async: prodt=%h valid=%b, want 0000ffff 1", prodt, valid);
            bad++;
        end
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (prodt !== 32'h0 || valid !== 1'b0) begin
            $display("FAIL async_clear: prodt=%h valid=%b, want 0 0", prodt, valid);
            bad++;
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [15:0] ah [2];
        logic [15:0] bh [2];
        logic [31:0] expv;
        ah[0] = '0; ah[1] = '0;
        bh[0] = '0; bh[1] = '0;
        start = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            mlier = 16'($urandom);
            mcand = 16'($urandom);
            if (k >= 2) begin
                expv = 32'(ah[0]) * 32'(bh[0]);
                total++;
                if (prodt !== expv || valid !== 1'b1) begin
                    $display("FAIL rand_%0d: prodt=%h valid=%b, want %h 1", k, prodt, valid, expv);
                    bad++;
                end
            end
            ah[0] = ah[1];
            bh[0] = bh[1];
            ah[1] = mlier;
            bh[1] = mcand;
            cyc();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        start = 1'b0;
        mlier = '0;
        mcand = '0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_stream_change();
        test_corners();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
